// File: rtl/fixed_divider_fsm_pkg.sv
// Shared constants, state encoding and Q-format width helpers for fixed_divider_fsm.
// Defining DIV_ROUND_EN adds one guard quotient bit for round-half-up results.
package fixed_divider_fsm_pkg;

  localparam int QM_DEFAULT = 10;
  localparam int QN_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } div_state_e;

`ifdef DIV_ROUND_EN
  localparam int GUARD_BITS = 1;
`else
  localparam int GUARD_BITS = 0;
`endif

  // Operand/result width of a signed Q m.n value.
  function automatic int q_width(input int m, input int n);
    return m + n;
  endfunction

  // Quotient bits produced by the divider: one per step, including any guard bit.
  function automatic int quo_width(input int m, input int n);
    return m + 2 * n + GUARD_BITS;
  endfunction

endpackage

// File: rtl/fixed_divider_fsm.sv
// Multi-cycle signed Q M.N divider: restoring division, one quotient bit per cycle,
// saturating on overflow and divide-by-zero. DIV_ROUND_EN enables half-up rounding.
module fixed_divider_fsm
  import fixed_divider_fsm_pkg::*;
#(
  parameter int M = QM_DEFAULT,
  parameter int N = QN_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [M+N-1:0]   i_num,
  input  logic [M+N-1:0]   i_den,
  input  logic             i_abs,
  output logic [M+N-1:0]   o_data,
  output logic             o_sat,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_state
);

  localparam int W  = q_width(M, N);
  localparam int QW = quo_width(M, N);
  localparam int CW = $clog2(QW);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_PREP = ST_PREP;
  localparam logic [1:0] S_DIV  = ST_DIV;
  localparam logic [1:0] S_FIN  = ST_FIN;

  localparam logic [W-1:0]  MAX_POS  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MAX_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);

  logic [1:0]    r_state;
  logic [W-1:0]  r_num;
  logic [W-1:0]  r_den;
  logic          r_abs;
  logic          r_sign;
  logic [W-1:0]  r_den_mag;
  logic [W-1:0]  r_rem;
  logic [QW-1:0] r_quo;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_data;
  logic          r_sat;
  logic          r_done;

  logic [W-1:0]  w_num_mag;
  logic [W-1:0]  w_den_mag;
  logic [W:0]    w_trial;
  logic [W:0]    w_diff;
  logic          w_fits;
  logic [QW-1:0] w_mag;
  logic [QW-1:0] w_limit;
  logic          w_neg;
  logic          w_ovf;
  logic          w_dz;
  logic [W-1:0]  w_res;

  // Magnitudes are W-bit unsigned, so -2^(W-1) maps cleanly to 2^(W-1).
  assign w_num_mag = r_num[W-1] ? (~r_num + W'(1)) : r_num;
  assign w_den_mag = r_den[W-1] ? (~r_den + W'(1)) : r_den;

  // The partial remainder stays below |den| <= 2^(W-1), so W+1 bits hold the trial.
  assign w_trial = {r_rem, r_quo[QW-1]};
  assign w_diff  = w_trial - {1'b0, r_den_mag};
  assign w_fits  = (w_trial >= {1'b0, r_den_mag});

`ifdef DIV_ROUND_EN
  assign w_mag = {1'b0, r_quo[QW-1:1]} + {{(QW-1){1'b0}}, r_quo[0]};
`else
  assign w_mag = r_quo;
`endif

  assign w_neg   = r_sign & ~r_abs;
  assign w_dz    = (r_den_mag == '0);
  assign w_limit = w_neg ? {{(QW-W){1'b0}}, MAX_NEG} : {{(QW-W){1'b0}}, MAX_POS};
  assign w_ovf   = (w_mag > w_limit);
  assign w_res   = w_neg ? (~w_mag[W-1:0] + W'(1)) : w_mag[W-1:0];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_num     <= '0;
      r_den     <= '0;
      r_abs     <= 1'b0;
      r_sign    <= 1'b0;
      r_den_mag <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_sat     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_num   <= i_num;
            r_den   <= i_den;
            r_abs   <= i_abs;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_sign    <= r_num[W-1] ^ r_den[W-1];
          r_den_mag <= w_den_mag;
          r_rem     <= '0;
          r_quo     <= {w_num_mag, {(QW-W){1'b0}}};
          // Divide-by-zero spends two cycles in FIN so its latency is a fixed 3.
          if (r_den == '0) begin
            r_cnt   <= CW'(1);
            r_state <= S_FIN;
          end else begin
            r_cnt   <= CNT_LAST;
            r_state <= S_DIV;
          end
        end
        S_DIV: begin
          r_rem <= w_fits ? w_diff[W-1:0] : w_trial[W-1:0];
          r_quo <= {r_quo[QW-2:0], w_fits};
          if (r_cnt == '0) begin
            r_state <= S_FIN;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_FIN: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
            if (w_dz || w_ovf) begin
              r_data <= w_neg ? MAX_NEG : MAX_POS;
              r_sat  <= 1'b1;
            end else begin
              r_data <= w_res;
              r_sat  <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_data  = r_data;
  assign o_sat   = r_sat;
  assign o_done  = r_done;
  assign o_busy  = (r_state != S_IDLE);
  assign o_state = r_state;

endmodule
